// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, mode constants and frame width.
// Imported by both ends of the SPI link.
package spi_pkg;

  // Default frame length in bits
  localparam int unsigned DEFAULT_WIDTH = 8;

  // FSM state encodings, 4 bits wide to match the debug state port
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SHIFT = 4'd1,
    DONE  = 4'd2
  } state_t;

  // SPI modes encoded as {polarity, phase}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_target_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI input, followed by an
// edge-detect flop that yields single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target: oversamples spi_clk/cs/mosi in the clk domain, receives frames
// MSB first into rx_data with a one-cycle rx_valid strobe, and transmits
// frames from a single-entry tx buffer on miso. All four SPI modes.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  polarity,
  input  logic                  phase,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic [3:0]            state,
  output logic [3:0]            count
);

  localparam logic [3:0] LAST_COUNT = 4'(DATA_WIDTH - 1);

  logic                   sclk_q, sclk_rise, sclk_fall;
  logic                   cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic                   sclk_edge, leading, trailing;
  logic                   sample_edge, shift_edge;
  logic                   frame_start;
  logic [DATA_WIDTH-1:0]  next_tx;
  logic [DATA_WIDTH-1:0]  rx_next;

  state_t                 state_r;
  logic [3:0]             count_r;
  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-2:0]  rx_sr;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic                   tx_full;
  logic [DATA_WIDTH-1:0]  rx_data_r;
  logic                   rx_valid_r;
  logic                   miso_r;
  logic                   hold_msb;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (spi_clk),
    .q     (sclk_q),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cs),
    .q     (cs_q),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi synchronizer; its last stage lines up with the spi_clk edge strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Classify synced spi_clk transitions into sample and shift edges by mode
  always_comb begin
    sclk_edge   = sclk_rise | sclk_fall;
    leading     = sclk_edge & (sclk_q ^ polarity);
    trailing    = sclk_edge & ~(sclk_q ^ polarity);
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    case ({polarity, phase})
      MODE0, MODE2: begin
        sample_edge = leading;
        shift_edge  = trailing;
      end
      MODE1, MODE3: begin
        sample_edge = trailing;
        shift_edge  = leading;
      end
      default: begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
      end
    endcase
  end

  // Frame start: cs falling from IDLE, or a shift edge in DONE with cs low
  always_comb begin
    frame_start = ~cs_rise &
                  (((state_r == IDLE) & cs_fall) |
                   ((state_r == DONE) & ~cs_q & shift_edge));
    next_tx     = tx_full ? tx_buf : '0;
    rx_next     = {rx_sr, mosi_s};
  end

  // Single-entry tx buffer; a load that coincides with a frame-start copy
  // refills the buffer for the following frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_load && !tx_full) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end else if (frame_start) begin
      tx_full <= 1'b0;
    end
  end

  // Frame FSM: shift registers, bit counter, miso and received-frame strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      miso_r     <= 1'b0;
      hold_msb   <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (cs_rise) begin
        state_r  <= IDLE;
        count_r  <= '0;
        miso_r   <= 1'b0;
        hold_msb <= 1'b0;
      end else if (frame_start) begin
        // From IDLE with phase=1 the first leading edge only re-presents the
        // MSB; a DONE reload is itself that first leading edge.
        tx_sr    <= next_tx;
        miso_r   <= next_tx[DATA_WIDTH-1];
        count_r  <= '0;
        hold_msb <= (state_r == IDLE) ? phase : 1'b0;
        state_r  <= SHIFT;
      end else if (state_r == SHIFT) begin
        if (sample_edge) begin
          rx_sr   <= rx_next[DATA_WIDTH-2:0];
          count_r <= count_r + 4'd1;
          if (count_r == LAST_COUNT) begin
            rx_data_r  <= rx_next;
            rx_valid_r <= 1'b1;
            state_r    <= DONE;
          end
        end else if (shift_edge) begin
          if (hold_msb) begin
            hold_msb <= 1'b0;
            miso_r   <= tx_sr[DATA_WIDTH-1];
          end else begin
            tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            miso_r <= tx_sr[DATA_WIDTH-2];
          end
        end
      end else if (state_r != IDLE && state_r != DONE) begin
        state_r <= IDLE;
      end
    end
  end

  assign miso     = miso_r;
  assign tx_ready = ~tx_full;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign state    = state_r;
  assign count    = count_r;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: all four modes, back-to-back frames,
// abort, underrun, ignored tx_load and reset in mid-frame.
`timescale 1ns/1ps
module tb_spi_target;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       spi_clk  = 1'b0;
  logic       cs       = 1'b1;
  logic       mosi     = 1'b0;
  logic       polarity = 1'b0;
  logic       phase    = 1'b0;
  logic [7:0] tx_data  = '0;
  logic       tx_load  = 1'b0;
  logic       miso;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] state;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  int         rx_pulses = 0;
  logic [7:0] rx_hist [0:31];

  spi_target #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .polarity (polarity),
    .phase    (phase),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .state    (state),
    .count    (count)
  );

  always #50 clk = ~clk;

  // Log every cycle rx_valid is high with the data presented alongside it
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rx_pulses % 32] = rx_data;
      rx_pulses = rx_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},     32'(miso),     32'h0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'h1);
    check({tag, "_rx_data"},  32'(rx_data),  32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_state"},    32'(state),    32'h0);
    check({tag, "_count"},    32'(count),    32'h0);
  endtask

  task automatic set_mode(input logic p, input logic h);
    polarity = p;
    phase    = h;
    spi_clk  = p;
    #800;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    #100;
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #800;
  endtask

  task automatic cs_high();
    #800;
    cs = 1'b1;
    #800;
  endtask

  // Master side: nbits bits of mo out on mosi, bits read from miso into mi
  task automatic shift_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!phase) begin
        mosi = mo[7-i];
        #400;
        spi_clk = ~polarity;
        mi = {mi[6:0], miso};
        #400;
        spi_clk = polarity;
      end else begin
        #400;
        spi_clk = ~polarity;
        mosi = mo[7-i];
        #400;
        spi_clk = polarity;
        mi = {mi[6:0], miso};
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int         p0;
    logic [1:0] md;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);
    #200;

    // Same exchange in all four modes
    for (int m = 0; m < 4; m++) begin
      md = 2'(m);
      set_mode(md[1], md[0]);
      p0 = rx_pulses;
      load(8'h5A);
      check($sformatf("mode%0d_ready_lo", m), 32'(tx_ready), 32'h0);
      cs_low();
      check($sformatf("mode%0d_ready_hi", m), 32'(tx_ready), 32'h1);
      shift_byte(8'hAF, 8, mi);
      #400;
      check($sformatf("mode%0d_end_state", m), 32'(state), md[0] ? 32'h2 : 32'h1);
      check($sformatf("mode%0d_end_count", m), 32'(count), md[0] ? 32'h8 : 32'h0);
      cs_high();
      check($sformatf("mode%0d_pulses", m), 32'(rx_pulses - p0), 32'h1);
      check($sformatf("mode%0d_rx", m), 32'(rx_hist[p0 % 32]), 32'hAF);
      check($sformatf("mode%0d_miso_rd", m), 32'(mi), 32'h5A);
      check($sformatf("mode%0d_idle_state", m), 32'(state), 32'h0);
      check($sformatf("mode%0d_idle_miso", m), 32'(miso), 32'h0);
    end

    // Back-to-back frames in mode 0, reload during the first frame
    set_mode(1'b0, 1'b0);
    p0 = rx_pulses;
    load(8'h5A);
    cs_low();
    check("b2b_ready_hi", 32'(tx_ready), 32'h1);
    load(8'h81);
    check("b2b_ready_lo", 32'(tx_ready), 32'h0);
    shift_byte(8'h3C, 8, mi);
    shift_byte(8'hC3, 8, mi2);
    cs_high();
    check("b2b_pulses", 32'(rx_pulses - p0), 32'h2);
    check("b2b_rx0", 32'(rx_hist[p0 % 32]), 32'h3C);
    check("b2b_rx1", 32'(rx_hist[(p0 + 1) % 32]), 32'hC3);
    check("b2b_miso0", 32'(mi), 32'h5A);
    check("b2b_miso1", 32'(mi2), 32'h81);
    check("b2b_ready_end", 32'(tx_ready), 32'h1);

    // Abort after 3 bits; the consumed tx byte is lost
    p0 = rx_pulses;
    load(8'h5A);
    cs_low();
    shift_byte(8'hFF, 3, mi);
    #400;
    check("abort_mid_count", 32'(count), 32'h3);
    check("abort_mid_state", 32'(state), 32'h1);
    cs = 1'b1;
    #800;
    check("abort_pulses", 32'(rx_pulses - p0), 32'h0);
    check("abort_rx_hold", 32'(rx_data), 32'hC3);
    check("abort_state", 32'(state), 32'h0);
    check("abort_count", 32'(count), 32'h0);
    check("abort_miso", 32'(miso), 32'h0);
    check("abort_ready", 32'(tx_ready), 32'h1);

    // Underrun: no load, master reads zeros
    p0 = rx_pulses;
    cs_low();
    shift_byte(8'h24, 4, mi);
    check("under_ready_mid", 32'(tx_ready), 32'h1);
    shift_byte(8'h24 << 4, 4, mi2);
    cs_high();
    check("under_miso", 32'({mi[3:0], mi2[3:0]}), 32'h00);
    check("under_rx", 32'(rx_hist[p0 % 32]), 32'h24);
    check("under_ready_end", 32'(tx_ready), 32'h1);

    // A load while the buffer is full is ignored
    p0 = rx_pulses;
    load(8'h5A);
    load(8'h99);
    check("ign_ready", 32'(tx_ready), 32'h0);
    cs_low();
    shift_byte(8'h66, 8, mi);
    cs_high();
    check("ign_miso", 32'(mi), 32'h5A);
    check("ign_rx", 32'(rx_hist[p0 % 32]), 32'h66);

    // Reset in mid-frame, then a full frame
    load(8'h5A);
    cs_low();
    shift_byte(8'hAF, 4, mi);
    #400;
    check("rst_mid_count", 32'(count), 32'h4);
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    cs = 1'b1;
    spi_clk = polarity;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #800;
    p0 = rx_pulses;
    load(8'h5A);
    cs_low();
    shift_byte(8'hAF, 8, mi);
    cs_high();
    check("post_rst_pulses", 32'(rx_pulses - p0), 32'h1);
    check("post_rst_rx", 32'(rx_hist[p0 % 32]), 32'hAF);
    check("post_rst_miso", 32'(mi), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral) end of the team's SPI link: receives `spi_clk`, `cs` and `mosi` from the existing SPI master block and drives `miso`. All four polarity/phase modes are supported and selected at runtime. SPI inputs are oversampled and synchronized into the `clk` domain. Received bytes are presented on a one-cycle valid strobe, and transmit bytes are taken from a single-entry buffer with a ready/load handshake.

## Interface
- `DATA_WIDTH`, 8, frame length in bits; MSB first.
- `SYNC_STAGES`, 2, synchronizer flops on each SPI input; minimum 2.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `spi_clk` in 1: SPI serial clock from the master; asynchronous to `clk`.
- `cs` in 1: chip select, active low.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master; driven 0 while `cs` is high.
- `polarity` in 1: CPOL, the idle level of `spi_clk`. Must be static while `cs` is low.
- `phase` in 1: CPHA. 0 = sample on leading edge; 1 = sample on trailing edge. Must be static while `cs` is low.
- `tx_data` in DATA_WIDTH: byte to transmit in the next frame.
- `tx_load` in 1: writes `tx_data` into the tx buffer when `tx_ready`=1; ignored otherwise.
- `tx_ready` out 1: tx buffer empty.
- `rx_data` out DATA_WIDTH: last complete received frame; held until the next frame completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `state` out 4: FSM state, for debug.
- `count` out 4: sample edges taken in the current frame (0..DATA_WIDTH).

## Operation
- Edge definitions:
  - Leading edge = `spi_clk` transition away from `polarity`; trailing edge = transition back.
  - Sample edge = leading if `phase`=0, trailing if `phase`=1. Shift edge = the other one.
- Inputs: `spi_clk`, `cs` and `mosi` each pass through SYNC_STAGES flops, followed by one edge-detect flop. `mosi` is delayed identically, so its sampled value is aligned with the detected edge.
- FSM states: IDLE=0, SHIFT=1, DONE=2.
  - IDLE: `miso`=0, `count`=0. On synced `cs` falling:
    - copy the tx buffer into the shift register (0x00 if the buffer is empty);
    - set `tx_ready`=1;
    - drive the shift-register MSB on `miso`;
    - go to SHIFT.
  - SHIFT:
    - Each sample edge: shift `mosi` into the rx shift register LSB; `count`+1.
    - Each shift edge: advance the tx shift register and present the next bit on `miso`.
    - With `phase`=1, the first shift edge (the first leading edge) re-presents the MSB; it does not advance.
    - When `count` reaches DATA_WIDTH: update `rx_data`, pulse `rx_valid`, go to DONE.
  - DONE: `cs` still low and a shift edge arrives → start the next frame back-to-back:
    - reload from the tx buffer (0x00 if empty) and present the MSB;
    - `count`=0; go to SHIFT.
- Synced `cs` rising in any state: go to IDLE.
  - A partial frame is discarded: no `rx_valid`, and `rx_data` is unchanged.
  - The tx byte already consumed is lost.
- `tx_load` is accepted in any state. A load in the same cycle as a frame-start copy is taken by the buffer for the following frame, and `tx_ready` stays 0.
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `state`=IDLE, `count`=0; tx buffer and shift registers = 0.

## Timing
- SPI-input-to-internal-event latency: SYNC_STAGES+1 `clk` cycles (3 at default).
- `miso` changes SYNC_STAGES+1 cycles after the shift edge at the pin (registered output).
- Constraints on the master:
  - `spi_clk` half period ≥ SYNC_STAGES+2 `clk` cycles (≥4 at default; spi_clk ≤ clk/8).
  - `cs` falling to first `spi_clk` edge ≥ SYNC_STAGES+2 cycles.
  - `cs` high time ≥ SYNC_STAGES+2 cycles.
- `rx_valid` asserts SYNC_STAGES+1 cycles after the final sample edge at the pin.
- `tx_ready` rises in the same cycle as the frame-start copy. `tx_load` takes effect on the next edge.

## Structure
- Shared package `spi_pkg`: state encodings (IDLE/SHIFT/DONE), mode constants MODE0..MODE3 as {polarity, phase}, default frame width 8. The existing master imports the same package.
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer plus rise/fall detect outputs. Instantiated for `spi_clk` and `cs`; `mosi` uses its synchronized output only.

## Test plan
- Mode 0, `clk` period 100 ns, master bit period 800 ns. Master sends 0xAF; tx buffer loaded with 0x5A → `rx_data`=0xAF with one `rx_valid` pulse; master reads 0x5A.
- Modes 1, 2, 3: repeat the same exchange → identical results. `miso` changes only after shift edges.
- Back-to-back: `cs` held low for 16 bits, 0x3C then 0xC3; reload 0x81 after `tx_ready` rises → two `rx_valid` pulses with 0x3C and 0xC3; master reads 0x5A then 0x81.
- Abort: `cs` deasserted after 3 bits → no `rx_valid`, `rx_data` holds its previous value, `state`=IDLE, `count`=0, `miso`=0.
- Underrun: frame with no `tx_load` → master reads 0x00, `tx_ready` stays 1; `tx_load` while `tx_ready`=0 is ignored.
- Reset asserted mid-frame (after bit 4) → all outputs take reset values immediately. The next full frame 0xAF is received correctly.
